jesd_sysref_lmfc_ti: RTL and testbench
======================================

Name: jesd_sysref_lmfc_ti

Overview:
- Consumes the single-ended SYSREF produced by the TI IO-buffer stage and brings it into the JESD204 core clock domain.
- Edge-detects SYSREF, applies a programmable capture delay and aligns a local multiframe (LMFC) counter to it.
- Provides the LMFC pulse and alignment status to the RX link layer (SYNC~/ILA timing), and flags SYSREF edges that arrive off the LMFC boundary.

Parameters:
- CNT_W, 8, LMFC counter width; LMFC period up to 2^CNT_W core cycles.
- DLY_W, 4, capture-delay field width; delay 0..2^DLY_W-1 cycles.

Ports:
- core_clk  in  1  core clock (refclk-derived).
- core_rst_n  in  1  asynchronous active-low reset.
- sysref  in  1  single-ended SYSREF from the IO-buffer stage; asynchronous to core_clk.
- lmfc_period_m1  in  CNT_W  LMFC period minus 1, in core cycles.
- sysref_delay  in  DLY_W  extra cycles between detected edge and LMFC alignment.
- resync_always  in  1  1 = realign on every misaligned edge; 0 = align on the first edge only.
- re_arm  in  1  one-cycle pulse that returns to WAIT_SYSREF.
- err_clr  in  1  one-cycle pulse that clears sysref_err.
- lmfc_pulse  out  1  one-cycle pulse at each LMFC boundary.
- lmfc_cnt  out  CNT_W  current LMFC phase.
- sysref_captured  out  1  high while ALIGNED.
- sysref_err  out  1  sticky: edge observed off the LMFC boundary.
- sysref_count  out  8  saturating count of captured edges (optional feature).

Behaviour:
- Reset values: all outputs 0; state WAIT_SYSREF; delay idle.
- Input stage: 2-FF synchroniser, then a registered rising-edge detector. sysref_edge is high in cycle N+3 for a rise sampled in cycle N.
- Delay stage:
  - On sysref_edge with delay idle, load the delay counter with sysref_delay; the event fires when the counter reaches 0.
  - sysref_delay=0 fires in the same cycle as sysref_edge.
  - Edges arriving while a delay is pending are discarded.
- FSM WAIT_SYSREF:
  - lmfc_cnt held at 0; no lmfc_pulse.
  - On fire: lmfc_cnt<=0, lmfc_pulse=1 in the following cycle, move to ALIGNED, sysref_captured<=1.
- FSM ALIGNED:
  - lmfc_cnt increments each cycle and wraps to 0 when lmfc_cnt >= lmfc_period_m1. Using >= handles a runtime period reduction.
  - lmfc_pulse is registered and high exactly in the cycles where lmfc_cnt==0.
  - lmfc_period_m1=0 gives lmfc_pulse continuously high.
- Fire while ALIGNED:
  - If the next lmfc_cnt would be 0: aligned, no action.
  - Otherwise set sysref_err. If resync_always=1, force lmfc_cnt<=0 and pulse; the period restarts from that point.
  - If resync_always=0, the phase is unchanged.
- re_arm:
  - Goes to WAIT_SYSREF, clears sysref_captured and lmfc_cnt, cancels any pending delay.
  - re_arm has priority over a simultaneous fire; that fire is dropped.
- err_clr clears sysref_err. A simultaneous new error wins (flag stays set).
- Asynchronous reset mid-operation clears everything immediately. The synchroniser flops also reset to 0, so a SYSREF held high at reset release produces an edge.

Optional Feature:
- Macro: SYSREF_EVENT_COUNT_EN
- Defined: sysref_count increments on every fire (aligned or not) and saturates at 255. It clears on reset and on re_arm.
- Not defined: sysref_count is tied to 0 and no counter logic is generated. All other behaviour is identical.

Decomposition:
- Shared package jesd204_ti_pkg:
  - FSM state enum (WAIT_SYSREF, ALIGNED).
  - Default CNT_W/DLY_W constants.
  - SYNC_STAGES=2.
- Sub-module sysref_sync_edge: 2-FF synchroniser plus rising-edge detector. Outputs sysref_edge; reused by the TX-side timing block.

Test Plan:
1. Basic alignment. Setup: lmfc_period_m1=15, delay=0, sysref rises at cycle 10. Required response:
   - first lmfc_pulse 4-5 cycles later;
   - pulses every 16 cycles after that;
   - sysref_captured=1, sysref_err=0.
2. Delay scaling. Same setup with delay=7: pulse timing shifts by exactly 7 cycles versus test 1.
3. Aligned periodic SYSREF. Second edge arrives exactly 32 cycles after the first: no err and no phase change.
4. Misaligned edge, no resync. Edge 5 cycles off the boundary with resync_always=0: sysref_err=1 and phase unchanged.
5. Misaligned edge with resync, then recovery. Same edge with resync_always=1:
   - lmfc restarts at the new edge;
   - err_clr then clears the flag.
6. Priority and reset. Required responses:
   - re_arm coincident with fire -> WAIT_SYSREF, lmfc_cnt=0, no pulse.
   - core_rst_n low mid-count -> all outputs 0 asynchronously.
   - With SYSREF_EVENT_COUNT_EN, 300 edges -> sysref_count=255.

Source files
------------

// File: rtl/jesd204_ti_pkg.sv
// Shared definitions for the TI JESD204 SYSREF/LMFC timing blocks (RX and TX side).
package jesd204_ti_pkg;

  localparam int DEF_CNT_W   = 8;
  localparam int DEF_DLY_W   = 4;
  localparam int SYNC_STAGES = 2;
  localparam logic [7:0] EVT_CNT_MAX = 8'hFF;

  typedef enum logic [0:0] {
    WAIT_SYSREF = 1'b0,
    ALIGNED     = 1'b1
  } lmfc_state_e;

endpackage

// File: rtl/sysref_sync_edge.sv
// SYNC_STAGES-deep synchroniser plus registered rising-edge detector for an async SYSREF.
// A rise sampled in cycle N shows up on sysref_edge in cycle N+3.
module sysref_sync_edge
  import jesd204_ti_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic sysref,
  output logic sysref_edge
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   edge_q;

  // Flops reset to 0 so a SYSREF already high at reset release still yields an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      edge_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sysref};
      prev_q <= sync_q[SYNC_STAGES-1];
      edge_q <= sync_q[SYNC_STAGES-1] & ~prev_q;
    end
  end

  assign sysref_edge = edge_q;

endmodule

// File: rtl/jesd_sysref_lmfc_ti.sv
// SYSREF capture, programmable delay and LMFC alignment for the JESD204 RX core clock domain.
// Optional saturating SYSREF event counter: define SYSREF_EVENT_COUNT_EN.
module jesd_sysref_lmfc_ti
  import jesd204_ti_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int DLY_W = DEF_DLY_W
) (
  input  logic             core_clk,
  input  logic             core_rst_n,
  input  logic             sysref,
  input  logic [CNT_W-1:0] lmfc_period_m1,
  input  logic [DLY_W-1:0] sysref_delay,
  input  logic             resync_always,
  input  logic             re_arm,
  input  logic             err_clr,
  output logic             lmfc_pulse,
  output logic [CNT_W-1:0] lmfc_cnt,
  output logic             sysref_captured,
  output logic             sysref_err,
  output logic [7:0]       sysref_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [DLY_W-1:0] DLY_ONE = {{(DLY_W-1){1'b0}}, 1'b1};

  logic             sysref_edge;
  logic             dly_busy;
  logic [DLY_W-1:0] dly_cnt;
  logic             fire;

  lmfc_state_e      state, state_nxt;
  logic [CNT_W-1:0] cnt_inc, cnt_nxt;
  logic             pulse_nxt;
  logic             err_set;

  sysref_sync_edge u_sync (
    .clk         (core_clk),
    .rst_n       (core_rst_n),
    .sysref      (sysref),
    .sysref_edge (sysref_edge)
  );

  // Zero delay fires combinationally with the edge; edges during a pending delay are dropped.
  assign fire = (dly_busy && dly_cnt == '0) ||
                (sysref_edge && !dly_busy && sysref_delay == '0);

  always_ff @(posedge core_clk or negedge core_rst_n) begin
    if (!core_rst_n) begin
      dly_busy <= 1'b0;
      dly_cnt  <= '0;
    end else if (re_arm) begin
      dly_busy <= 1'b0;
      dly_cnt  <= '0;
    end else if (dly_busy) begin
      if (dly_cnt == '0) dly_busy <= 1'b0;
      else               dly_cnt  <= dly_cnt - DLY_ONE;
    end else if (sysref_edge && sysref_delay != '0) begin
      dly_busy <= 1'b1;
      dly_cnt  <= sysref_delay - DLY_ONE;
    end
  end

  always_ff @(posedge core_clk or negedge core_rst_n) begin
    if (!core_rst_n) state <= WAIT_SYSREF;
    else             state <= state_nxt;
  end

  // >= rather than == so a period shrunk below the current phase still wraps.
  assign cnt_inc = (lmfc_cnt >= lmfc_period_m1) ? '0 : lmfc_cnt + CNT_ONE;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = lmfc_cnt;
    err_set   = 1'b0;
    case (state)
      WAIT_SYSREF: begin
        cnt_nxt = '0;
        if (fire) state_nxt = ALIGNED;
      end
      ALIGNED: begin
        cnt_nxt = cnt_inc;
        if (fire && cnt_inc != '0) begin
          err_set = 1'b1;
          if (resync_always) cnt_nxt = '0;
        end
      end
      default: state_nxt = WAIT_SYSREF;
    endcase
    if (re_arm) begin
      state_nxt = WAIT_SYSREF;
      cnt_nxt   = '0;
      err_set   = 1'b0;
    end
    pulse_nxt = (state_nxt == ALIGNED) && (cnt_nxt == '0);
  end

  always_ff @(posedge core_clk or negedge core_rst_n) begin
    if (!core_rst_n) begin
      lmfc_cnt   <= '0;
      lmfc_pulse <= 1'b0;
      sysref_err <= 1'b0;
    end else begin
      lmfc_cnt   <= cnt_nxt;
      lmfc_pulse <= pulse_nxt;
      sysref_err <= err_set | (sysref_err & ~err_clr);
    end
  end

  assign sysref_captured = (state == ALIGNED);

`ifdef SYSREF_EVENT_COUNT_EN
  logic [7:0] evt_cnt;

  always_ff @(posedge core_clk or negedge core_rst_n) begin
    if (!core_rst_n)                      evt_cnt <= '0;
    else if (re_arm)                      evt_cnt <= '0;
    else if (fire && evt_cnt != EVT_CNT_MAX) evt_cnt <= evt_cnt + 8'd1;
  end

  assign sysref_count = evt_cnt;
`else
  assign sysref_count = '0;
`endif

endmodule

// File: tb/tb_jesd_sysref_lmfc_ti.sv
// Directed bench for jesd_sysref_lmfc_ti: alignment, delay, error/resync, priority, reset, event count.
module tb_jesd_sysref_lmfc_ti;

  logic       core_clk = 1'b0;
  logic       core_rst_n = 1'b0;
  logic       sysref = 1'b0;
  logic [7:0] lmfc_period_m1 = 8'd15;
  logic [3:0] sysref_delay = 4'd0;
  logic       resync_always = 1'b0;
  logic       re_arm = 1'b0;
  logic       err_clr = 1'b0;
  logic       lmfc_pulse;
  logic [7:0] lmfc_cnt;
  logic       sysref_captured;
  logic       sysref_err;
  logic [7:0] sysref_count;

  int errs = 0;
  int checks = 0;

`ifdef SYSREF_EVENT_COUNT_EN
  localparam logic [7:0] EXP_ONE = 8'd1;
  localparam logic [7:0] EXP_SAT = 8'd255;
`else
  localparam logic [7:0] EXP_ONE = 8'd0;
  localparam logic [7:0] EXP_SAT = 8'd0;
`endif

  jesd_sysref_lmfc_ti dut (
    .core_clk        (core_clk),
    .core_rst_n      (core_rst_n),
    .sysref          (sysref),
    .lmfc_period_m1  (lmfc_period_m1),
    .sysref_delay    (sysref_delay),
    .resync_always   (resync_always),
    .re_arm          (re_arm),
    .err_clr         (err_clr),
    .lmfc_pulse      (lmfc_pulse),
    .lmfc_cnt        (lmfc_cnt),
    .sysref_captured (sysref_captured),
    .sysref_err      (sysref_err),
    .sysref_count    (sysref_count)
  );

  always #5 core_clk = ~core_clk;

  task automatic adv(input int n);
    repeat (n) @(negedge core_clk);
  endtask

  // Returns to WAIT_SYSREF, then raises sysref; the calling negedge is cycle 0.
  task automatic align_fresh(input logic [3:0] d);
    sysref = 1'b0;
    adv(5);
    re_arm = 1'b1;
    adv(1);
    re_arm = 1'b0;
    sysref_delay = d;
    sysref = 1'b1;
  endtask

  task automatic test_reset;
    #12;
    checks++; if (lmfc_pulse !== 1'b0) begin errs++; $display("FAIL rst_pulse: got %b want 0", lmfc_pulse); end
    checks++; if (lmfc_cnt !== 8'd0) begin errs++; $display("FAIL rst_cnt: got %0d want 0", lmfc_cnt); end
    checks++; if (sysref_captured !== 1'b0) begin errs++; $display("FAIL rst_captured: got %b want 0", sysref_captured); end
    checks++; if (sysref_err !== 1'b0) begin errs++; $display("FAIL rst_err: got %b want 0", sysref_err); end
    checks++; if (sysref_count !== 8'd0) begin errs++; $display("FAIL rst_count: got %0d want 0", sysref_count); end
    @(negedge core_clk);
    core_rst_n = 1'b1;
    adv(6);
    checks++; if (sysref_captured !== 1'b0) begin errs++; $display("FAIL idle_captured: got %b want 0", sysref_captured); end
  endtask

  task automatic test_basic_align;
    lmfc_period_m1 = 8'd15;
    align_fresh(4'd0);
    adv(3);
    checks++; if (lmfc_pulse !== 1'b0 || sysref_captured !== 1'b0) begin errs++; $display("FAIL basic_early: pulse=%b cap=%b want 0 0", lmfc_pulse, sysref_captured); end
    adv(1);
    checks++; if (lmfc_pulse !== 1'b1 || lmfc_cnt !== 8'd0) begin errs++; $display("FAIL basic_first_pulse: pulse=%b cnt=%0d want 1 0", lmfc_pulse, lmfc_cnt); end
    checks++; if (sysref_captured !== 1'b1 || sysref_err !== 1'b0) begin errs++; $display("FAIL basic_status: cap=%b err=%b want 1 0", sysref_captured, sysref_err); end
    checks++; if (sysref_count !== EXP_ONE) begin errs++; $display("FAIL basic_count: got %0d want %0d", sysref_count, EXP_ONE); end
    adv(1);
    checks++; if (lmfc_pulse !== 1'b0 || lmfc_cnt !== 8'd1) begin errs++; $display("FAIL basic_after: pulse=%b cnt=%0d want 0 1", lmfc_pulse, lmfc_cnt); end
    adv(14);
    checks++; if (lmfc_pulse !== 1'b0 || lmfc_cnt !== 8'd15) begin errs++; $display("FAIL basic_c19: pulse=%b cnt=%0d want 0 15", lmfc_pulse, lmfc_cnt); end
    adv(1);
    checks++; if (lmfc_pulse !== 1'b1) begin errs++; $display("FAIL basic_pulse20: got %b want 1", lmfc_pulse); end
    adv(16);
    checks++; if (lmfc_pulse !== 1'b1) begin errs++; $display("FAIL basic_pulse36: got %b want 1", lmfc_pulse); end
  endtask

  task automatic test_delay;
    align_fresh(4'd7);
    adv(10);
    checks++; if (lmfc_pulse !== 1'b0 || sysref_captured !== 1'b0) begin errs++; $display("FAIL delay_early: pulse=%b cap=%b want 0 0", lmfc_pulse, sysref_captured); end
    adv(1);
    checks++; if (lmfc_pulse !== 1'b1 || lmfc_cnt !== 8'd0 || sysref_captured !== 1'b1) begin errs++; $display("FAIL delay_first: pulse=%b cnt=%0d cap=%b want 1 0 1", lmfc_pulse, lmfc_cnt, sysref_captured); end
    adv(16);
    checks++; if (lmfc_pulse !== 1'b1) begin errs++; $display("FAIL delay_period: got %b want 1", lmfc_pulse); end
  endtask

  task automatic test_aligned_periodic;
    align_fresh(4'd0);
    adv(8);  sysref = 1'b0;
    adv(24); sysref = 1'b1;
    adv(4);
    checks++; if (lmfc_pulse !== 1'b1 || lmfc_cnt !== 8'd0 || sysref_err !== 1'b0) begin errs++; $display("FAIL periodic: pulse=%b cnt=%0d err=%b want 1 0 0", lmfc_pulse, lmfc_cnt, sysref_err); end
    adv(1);
    checks++; if (lmfc_cnt !== 8'd1) begin errs++; $display("FAIL periodic_phase: got %0d want 1", lmfc_cnt); end
  endtask

  task automatic test_misaligned;
    resync_always = 1'b0;
    align_fresh(4'd0);
    adv(8);  sysref = 1'b0;
    adv(29); sysref = 1'b1;
    adv(3);
    checks++; if (sysref_err !== 1'b0) begin errs++; $display("FAIL mis_pre_err: got %b want 0", sysref_err); end
    adv(1);
    checks++; if (sysref_err !== 1'b1 || lmfc_cnt !== 8'd5 || lmfc_pulse !== 1'b0) begin errs++; $display("FAIL mis_noresync: err=%b cnt=%0d pulse=%b want 1 5 0", sysref_err, lmfc_cnt, lmfc_pulse); end
    adv(11);
    checks++; if (lmfc_pulse !== 1'b1 || lmfc_cnt !== 8'd0) begin errs++; $display("FAIL mis_phase: pulse=%b cnt=%0d want 1 0", lmfc_pulse, lmfc_cnt); end
  endtask

  task automatic test_resync;
    err_clr = 1'b1; adv(1); err_clr = 1'b0;
    checks++; if (sysref_err !== 1'b0) begin errs++; $display("FAIL resync_clr0: got %b want 0", sysref_err); end
    resync_always = 1'b1;
    align_fresh(4'd0);
    adv(8);  sysref = 1'b0;
    adv(29); sysref = 1'b1;
    adv(4);
    checks++; if (sysref_err !== 1'b1 || lmfc_cnt !== 8'd0 || lmfc_pulse !== 1'b1) begin errs++; $display("FAIL resync_restart: err=%b cnt=%0d pulse=%b want 1 0 1", sysref_err, lmfc_cnt, lmfc_pulse); end
    adv(11);
    checks++; if (lmfc_pulse !== 1'b0) begin errs++; $display("FAIL resync_oldphase: got %b want 0", lmfc_pulse); end
    adv(5);
    checks++; if (lmfc_pulse !== 1'b1) begin errs++; $display("FAIL resync_newphase: got %b want 1", lmfc_pulse); end
    err_clr = 1'b1; adv(1); err_clr = 1'b0;
    sysref = 1'b0;
    checks++; if (sysref_err !== 1'b0) begin errs++; $display("FAIL resync_clr: got %b want 0", sysref_err); end
    adv(2); sysref = 1'b1;
    adv(3); err_clr = 1'b1;
    adv(1); err_clr = 1'b0;
    checks++; if (sysref_err !== 1'b1 || lmfc_cnt !== 8'd0) begin errs++; $display("FAIL err_clr_vs_set: err=%b cnt=%0d want 1 0", sysref_err, lmfc_cnt); end
    resync_always = 1'b0;
  endtask

  task automatic test_period_zero;
    align_fresh(4'd0);
    adv(4);
    lmfc_period_m1 = 8'd0;
    for (int i = 0; i < 3; i++) begin
      adv(1);
      checks++; if (lmfc_pulse !== 1'b1 || lmfc_cnt !== 8'd0) begin errs++; $display("FAIL period0_%0d: pulse=%b cnt=%0d want 1 0", i, lmfc_pulse, lmfc_cnt); end
    end
    lmfc_period_m1 = 8'd15;
  endtask

  task automatic test_priority;
    err_clr = 1'b1; adv(1); err_clr = 1'b0;
    align_fresh(4'd0);
    adv(8); sysref = 1'b0;
    adv(2); sysref = 1'b1;
    adv(3); re_arm = 1'b1;
    adv(1); re_arm = 1'b0;
    checks++; if (sysref_captured !== 1'b0 || lmfc_cnt !== 8'd0 || lmfc_pulse !== 1'b0) begin errs++; $display("FAIL rearm_fire: cap=%b cnt=%0d pulse=%b want 0 0 0", sysref_captured, lmfc_cnt, lmfc_pulse); end
    checks++; if (sysref_err !== 1'b0 || sysref_count !== 8'd0) begin errs++; $display("FAIL rearm_drop: err=%b count=%0d want 0 0", sysref_err, sysref_count); end
    adv(1);
    checks++; if (sysref_captured !== 1'b0 || lmfc_pulse !== 1'b0) begin errs++; $display("FAIL rearm_stay: cap=%b pulse=%b want 0 0", sysref_captured, lmfc_pulse); end
  endtask

  task automatic test_async_reset;
    align_fresh(4'd0);
    adv(10);
    #2 core_rst_n = 1'b0;
    #1;
    checks++; if (lmfc_cnt !== 8'd0 || sysref_captured !== 1'b0 || lmfc_pulse !== 1'b0) begin errs++; $display("FAIL async_rst: cnt=%0d cap=%b pulse=%b want 0 0 0", lmfc_cnt, sysref_captured, lmfc_pulse); end
    checks++; if (sysref_err !== 1'b0 || sysref_count !== 8'd0) begin errs++; $display("FAIL async_rst_flags: err=%b count=%0d want 0 0", sysref_err, sysref_count); end
    @(negedge core_clk);
    core_rst_n = 1'b1;
    adv(4);
    checks++; if (lmfc_pulse !== 1'b1 || sysref_captured !== 1'b1) begin errs++; $display("FAIL rst_release_edge: pulse=%b cap=%b want 1 1", lmfc_pulse, sysref_captured); end
  endtask

  task automatic test_event_count;
    sysref = 1'b0;
    adv(5);
    re_arm = 1'b1; adv(1); re_arm = 1'b0;
    for (int i = 0; i < 300; i++) begin
      sysref = 1'b1; adv(1);
      sysref = 1'b0; adv(1);
    end
    adv(6);
    checks++; if (sysref_count !== EXP_SAT) begin errs++; $display("FAIL event_count: got %0d want %0d", sysref_count, EXP_SAT); end
  endtask

  initial begin
    test_reset();
    test_basic_align();
    test_delay();
    test_aligned_periodic();
    test_misaligned();
    test_resync();
    test_period_zero();
    test_priority();
    test_async_reset();
    test_event_count();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
